canvas_write_sequencer: RTL



---
 rtl/canvas_write_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/canvas_write_sequencer.sv
// canvas_write_sequencer: arbitrates the canvas RAM write port between brush stamps and full clears.
module canvas_write_sequencer #(
  parameter int CANVAS_W    = 48,
  parameter int CANVAS_H    = 48,
  parameter int COLOR_W     = 3,
  parameter int CLEAR_COLOR = 0,
  parameter int ADDR_W      = 12
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [5:0]         req_x,
  input  logic [5:0]         req_y,
  input  logic [COLOR_W-1:0] req_color,
  input  logic [1:0]         req_width,
  input  logic               clear_req,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               clear_done
);
  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;
  localparam int N = CANVAS_W * CANVAS_H;
  state_t state, state_n;
  logic clear_pending, pending_n;
  logic [5:0] x, y, x_n, y_n;
  logic [COLOR_W-1:0] color, color_n, data_n;
  logic [1:0] w, w_n, dx, dy, dx_n, dy_n;
  logic [ADDR_W-1:0] a, a_n, addr_n;
  logic wr_en_n, busy_n, done_n, row_end;
  logic [6:0] cx, cy;
  assign req_ready = (state == IDLE) & !clear_pending & !clear_req & !clr;
  assign row_end = dx == w - 2'd1;
  always_comb begin
    state_n = state;
    pending_n = clear_pending | (clear_req & (state != CLEAR));
    x_n = x;
    y_n = y;
    color_n = color;
    w_n = w;
    dx_n = dx;
    dy_n = dy;
    a_n = a;
    wr_en_n = 1'b0;
    addr_n = wr_addr;
    data_n = wr_data;
    busy_n = 1'b0;
    done_n = 1'b0;
    cx = '0;
    cy = '0;
    case (state)
      IDLE:
        if (clear_pending | clear_req) begin
          state_n = CLEAR;
          pending_n = 1'b0;
          a_n = '0;
          wr_en_n = 1'b1;
          addr_n = '0;
          data_n = COLOR_W'(CLEAR_COLOR);
          busy_n = 1'b1;
        end else if (req_valid & req_ready) begin
          state_n = PAINT;
          x_n = req_x;
          y_n = req_y;
          color_n = req_color;
          w_n = req_width == 2'd0 ? 2'd1 : req_width;
          dx_n = '0;
          dy_n = '0;
        end
      PAINT:
        if (row_end && dy == w - 2'd1) state_n = IDLE;
        else begin
          dx_n = row_end ? 2'd0 : dx + 2'd1;
          dy_n = row_end ? dy + 2'd1 : dy;
        end
      CLEAR:
        if (a == ADDR_W'(N - 1)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          a_n = a + ADDR_W'(1);
          wr_en_n = 1'b1;
          addr_n = a + ADDR_W'(1);
          data_n = COLOR_W'(CLEAR_COLOR);
          busy_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
    // Outputs are registered, so the cell presented next cycle is derived from the next counters.
    if (state_n == PAINT) begin
      cx = {1'b0, x_n} + {5'd0, dx_n};
      cy = {1'b0, y_n} + {5'd0, dy_n};
      wr_en_n = (cx < 7'(CANVAS_W)) & (cy < 7'(CANVAS_H));
      addr_n = ADDR_W'(int'(cy) * CANVAS_W + int'(cx));
      data_n = color_n;
      busy_n = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      clear_pending <= 1'b0;
      x <= '0;
      y <= '0;
      color <= '0;
      w <= 2'd1;
      dx <= '0;
      dy <= '0;
      a <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state <= state_n;
      clear_pending <= pending_n;
      x <= x_n;
      y <= y_n;
      color <= color_n;
      w <= w_n;
      dx <= dx_n;
      dy <= dy_n;
      a <= a_n;
      wr_en <= wr_en_n;
      wr_addr <= addr_n;
      wr_data <= data_n;
      busy <= busy_n;
      clear_done <= done_n;
    end
endmodule
